// File: rtl/spi_reg_bridge_if.sv
// spi_reg_bridge_if
//   Bundles the SPI-side byte handshake and the register bus of the
//   SPI-to-register bridge.
//   modport master : the bridge. It drives tx_data, the register bus
//                    strobes/address/data and active.
//   modport slave  : the environment. It is the SPI slave core plus the
//                    register file, and it drives ss, rx_done, rx_data
//                    and reg_rdata.
interface spi_reg_bridge_if;
  logic       ss;         // raw slave-select pin, active-low, async to clk
  logic       rx_done;    // one-cycle pulse: byte received
  logic [7:0] rx_data;    // received byte, valid with rx_done
  logic [7:0] tx_data;    // next byte for the SPI slave to shift out
  logic [6:0] reg_addr;   // register bus address
  logic [7:0] reg_wdata;  // register bus write data
  logic       reg_wr;     // one-cycle write strobe
  logic       reg_rd;     // one-cycle read strobe
  logic [7:0] reg_rdata;  // read data, valid the cycle after reg_rd
  logic       active;     // frame in progress

  modport master (
    input  ss, rx_done, rx_data, reg_rdata,
    output tx_data, reg_addr, reg_wdata, reg_wr, reg_rd, active
  );

  modport slave (
    output ss, rx_done, rx_data, reg_rdata,
    input  tx_data, reg_addr, reg_wdata, reg_wr, reg_rd, active
  );
endinterface

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge
//   Turns SPI byte frames into register bus accesses. The first byte of a
//   frame is the command: bit7 selects read (1) or write (0), and bits
//   [6:0] give the start address. In a write frame, each later byte is
//   written. In a read frame, each byte fetches a register, and the
//   register value is what the SPI slave shifts out next.
//   Ports:
//     clk  - system clock, rising edge
//     rst  - synchronous active-high reset
//     bus  - spi_reg_bridge_if.master (SPI handshake + register bus)
//   Optional feature: define SPI_BRIDGE_AUTOINC_EN to step the address
//   by one (mod 128) per data byte. Without it, every access in a frame
//   goes to the command address.
//
//   state | meaning
//   IDLE  | no frame; tx_data holds the 8'hA5 sync byte
//   CMD   | frame open, waiting for the command byte
//   WR    | write frame; each byte becomes a reg_wr
//   RD    | read frame; each byte fetches the next register into tx_data
module spi_reg_bridge (
  input  logic              clk,
  input  logic              rst,
  spi_reg_bridge_if.master  bus
);
  typedef enum logic [1:0] {IDLE, CMD, WR, RD} state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  state_t     state, state_next;
  logic       ss_meta, ss_s;
  logic       cmd_load, wr_fire, rd_fire, rd_adv;
  logic       rd_pend;
  logic [6:0] addr_step;

  always_ff @(posedge clk) begin
    if (rst) begin
      ss_meta <= 1'b1;
      ss_s    <= 1'b1;
    end else begin
      ss_meta <= bus.ss;
      ss_s    <= ss_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    cmd_load   = 1'b0;
    wr_fire    = 1'b0;
    rd_fire    = 1'b0;
    rd_adv     = 1'b0;
    unique case (state)
      IDLE: if (!ss_s) state_next = CMD;
      CMD: begin
        if (ss_s) begin
          state_next = IDLE;
        end else if (bus.rx_done) begin
          cmd_load   = 1'b1;
          rd_fire    = bus.rx_data[7];
          state_next = bus.rx_data[7] ? RD : WR;
        end
      end
      WR: begin
        // A byte that lands together with the frame end is still written.
        wr_fire = bus.rx_done;
        if (ss_s) state_next = IDLE;
      end
      RD: begin
        if (ss_s) begin
          state_next = IDLE;
        end else if (bus.rx_done) begin
          rd_fire = 1'b1;
          rd_adv  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef SPI_BRIDGE_AUTOINC_EN
  assign addr_step = bus.reg_addr + 7'd1;
`else
  assign addr_step = bus.reg_addr;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.reg_addr  <= 7'd0;
      bus.reg_wdata <= 8'd0;
      bus.reg_wr    <= 1'b0;
      bus.reg_rd    <= 1'b0;
      bus.tx_data   <= SYNC_BYTE;
      rd_pend       <= 1'b0;
    end else begin
      bus.reg_wr <= wr_fire;
      bus.reg_rd <= rd_fire;
      rd_pend    <= bus.reg_rd;
      if (wr_fire) bus.reg_wdata <= bus.rx_data;
      // Writes step the address after the strobe. Reads step it before
      // the strobe, so reg_rd already sees the new address.
      if (cmd_load)                  bus.reg_addr <= bus.rx_data[6:0];
      else if (bus.reg_wr || rd_adv) bus.reg_addr <= addr_step;
      // The sync byte wins as soon as the frame closes, even if a read
      // is still in flight.
      if (state_next == IDLE || state_next == CMD) bus.tx_data <= SYNC_BYTE;
      else if (rd_pend)                            bus.tx_data <= bus.reg_rdata;
    end
  end

  assign bus.active = (state != IDLE);
endmodule

// File: tb/tb_spi_reg_bridge.sv
module tb_spi_reg_bridge;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   wr_cnt = 0;
  int   rd_cnt = 0;
  int   both_cnt = 0;
  int   wr_snap;

  spi_reg_bridge_if bus ();

  spi_reg_bridge dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Register model: the read value is the 7-bit address plus 8'hC0, so
  // address 0x03 returns 0xC3 and address 0x04 returns 0xC4.
  always @(posedge clk) begin
    if (bus.reg_rd) bus.reg_rdata <= {1'b0, bus.reg_addr} + 8'hC0;
    if (bus.reg_wr) wr_cnt <= wr_cnt + 1;
    if (bus.reg_rd) rd_cnt <= rd_cnt + 1;
    if (bus.reg_wr && bus.reg_rd) both_cnt <= both_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // After this returns, the bench is in the cycle just after rx_done.
  task automatic pulse(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    tick();
    bus.rx_done = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  logic [6:0] exp_wr2, exp_wrap, exp_rd2;
  logic [7:0] exp_tx2;

  initial begin
`ifdef SPI_BRIDGE_AUTOINC_EN
    exp_wr2  = 7'h06;
    exp_wrap = 7'h00;
    exp_rd2  = 7'h04;
    exp_tx2  = 8'hC4;
`else
    exp_wr2  = 7'h05;
    exp_wrap = 7'h7F;
    exp_rd2  = 7'h03;
    exp_tx2  = 8'hC3;
`endif
    rst = 1'b1;
    bus.ss = 1'b1;
    bus.rx_done = 1'b0;
    bus.rx_data = 8'h00;
    bus.reg_rdata = 8'h00;
    idle(2);
    rst = 1'b0;
    tick();
    chk("rst_tx", bus.tx_data, 8'hA5);
    chk("rst_addr", bus.reg_addr, 7'h00);
    chk("rst_wdata", bus.reg_wdata, 8'h00);
    chk("rst_wr", bus.reg_wr, 1'b0);
    chk("rst_rd", bus.reg_rd, 1'b0);
    chk("rst_active", bus.active, 1'b0);

    // A byte while no frame is open is ignored
    pulse(8'h05);
    chk("idle_wr", bus.reg_wr, 1'b0);
    chk("idle_rd", bus.reg_rd, 1'b0);
    idle(3);
    chk("idle_cnt", wr_cnt + rd_cnt, 0);

    // Write frame: 0x05, 0x11, 0x22
    bus.ss = 1'b0;
    idle(3);
    chk("wf_active", bus.active, 1'b1);
    chk("wf_tx_cmd", bus.tx_data, 8'hA5);
    pulse(8'h05);
    chk("wf_cmd_addr", bus.reg_addr, 7'h05);
    chk("wf_cmd_nowr", bus.reg_wr, 1'b0);
    idle(3);
    pulse(8'h11);
    chk("wf1_wr", bus.reg_wr, 1'b1);
    chk("wf1_addr", bus.reg_addr, 7'h05);
    chk("wf1_data", bus.reg_wdata, 8'h11);
    chk("wf1_rd", bus.reg_rd, 1'b0);
    tick();
    chk("wf1_wr_once", bus.reg_wr, 1'b0);
    idle(2);
    pulse(8'h22);
    chk("wf2_wr", bus.reg_wr, 1'b1);
    chk("wf2_addr", bus.reg_addr, exp_wr2);
    chk("wf2_data", bus.reg_wdata, 8'h22);
    idle(3);
    bus.ss = 1'b1;
    idle(3);
    chk("wf_end_active", bus.active, 1'b0);
    chk("wf_wr_cnt", wr_cnt, 2);

    // Read frame: cmd 0x83, then one more byte
    bus.ss = 1'b0;
    idle(3);
    pulse(8'h83);
    chk("rf_rd", bus.reg_rd, 1'b1);
    chk("rf_addr", bus.reg_addr, 7'h03);
    chk("rf_wr", bus.reg_wr, 1'b0);
    tick();
    chk("rf_rd_once", bus.reg_rd, 1'b0);
    chk("rf_tx_early", bus.tx_data, 8'hA5);
    tick();
    chk("rf_tx1", bus.tx_data, 8'hC3);
    tick();
    pulse(8'hEE);
    chk("rf2_rd", bus.reg_rd, 1'b1);
    chk("rf2_addr", bus.reg_addr, exp_rd2);
    idle(2);
    chk("rf_tx2", bus.tx_data, exp_tx2);
    tick();
    bus.ss = 1'b1;
    idle(3);
    chk("rf_tx_sync", bus.tx_data, 8'hA5);
    chk("rf_active", bus.active, 1'b0);

    // Address wrap
    bus.ss = 1'b0;
    idle(3);
    pulse(8'h7F);
    idle(3);
    pulse(8'hAA);
    chk("wrap1_addr", bus.reg_addr, 7'h7F);
    chk("wrap1_data", bus.reg_wdata, 8'hAA);
    idle(3);
    pulse(8'hBB);
    chk("wrap2_wr", bus.reg_wr, 1'b1);
    chk("wrap2_addr", bus.reg_addr, exp_wrap);
    idle(3);
    bus.ss = 1'b1;
    idle(3);

    // Abort after command with no data
    wr_snap = wr_cnt;
    bus.ss = 1'b0;
    idle(3);
    pulse(8'h10);
    chk("abort_addr", bus.reg_addr, 7'h10);
    tick();
    bus.ss = 1'b1;
    idle(3);
    chk("abort_active", bus.active, 1'b0);
    chk("abort_nowr", wr_cnt, wr_snap);

    // Byte landing in the same cycle the frame closes is still written
    bus.ss = 1'b0;
    idle(3);
    pulse(8'h20);
    idle(3);
    bus.ss = 1'b1;
    idle(2);
    pulse(8'h5A);
    chk("late_wr", bus.reg_wr, 1'b1);
    chk("late_data", bus.reg_wdata, 8'h5A);
    chk("late_addr", bus.reg_addr, 7'h20);
    chk("late_active", bus.active, 1'b0);
    idle(3);

    // Reset mid-frame with a byte arriving in the reset cycle
    bus.ss = 1'b0;
    idle(3);
    pulse(8'h30);
    idle(3);
    wr_snap = wr_cnt;
    bus.rx_data = 8'h77;
    bus.rx_done = 1'b1;
    rst = 1'b1;
    tick();
    bus.rx_done = 1'b0;
    bus.ss = 1'b1;
    chk("mrst_wr", bus.reg_wr, 1'b0);
    chk("mrst_rd", bus.reg_rd, 1'b0);
    chk("mrst_addr", bus.reg_addr, 7'h00);
    chk("mrst_wdata", bus.reg_wdata, 8'h00);
    chk("mrst_tx", bus.tx_data, 8'hA5);
    chk("mrst_active", bus.active, 1'b0);
    rst = 1'b0;
    idle(3);
    chk("mrst_nowr", wr_cnt, wr_snap);
    pulse(8'h44);
    chk("ssh_wr", bus.reg_wr, 1'b0);
    chk("ssh_rd", bus.reg_rd, 1'b0);
    idle(3);
    chk("ssh_nowr", wr_cnt, wr_snap);
    chk("wr_rd_overlap", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
